// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// No logic; the response-state enum and default parameter values only.
// Imported by dmem_arb_age_ctr and dmem_arbiter.
package dmem_arb_pkg;

    localparam int DEF_AW           = 8;
    localparam int DEF_DW           = 8;
    localparam int DEF_STARVE_LIMIT = 4;
    // Wide enough for the largest legal starve limit (15).
    localparam int AGE_W            = 4;

    // Which port, if any, is owed a read response this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } rsp_state_t;

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Debug-port age counter: counts cycles debug waits, raises starve at the limit.
// Latency: starve is registered-state derived, valid in the cycle the count is reached.
// Backpressure: none; counter saturates at STARVE_LIMIT and clears on grant or req drop.
// Ports: clk, rst_n (async active-low), dbg_req, dbg_gnt in; starve out.
module dmem_arb_age_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic starve
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            age <= '0;
        end else if (age != LIMIT) begin
            age <= age + AGE_W'(1);
        end
    end

    // Derived only from the register, so the grant logic that consumes it
    // has no combinational loop back through dbg_gnt.
    assign starve = (age == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU, debug host) arbiter in front of a single-port synchronous RAM.
// Latency: grant same cycle as request; read data returned exactly 1 cycle after grant.
// Backpressure: ungranted requester holds req/addr/data; CPU priority, debug wins after STARVE_LIMIT waits.
// Ports: clk, rst_n; cpu_* and dbg_* request/response ports; mem_* RAM port;
//        debug_dout trace of CPU store data / load results; busy = response pending.
// Optional: define DMEM_ARB_TRACE_EN to build the debug_dout trace register
//           (otherwise debug_dout is tied to 0).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] debug_dout,
    output logic          busy
);

    rsp_state_t state;
    rsp_state_t state_nxt;
    logic       starve;

    dmem_arb_age_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_age_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .dbg_req (dbg_req),
        .dbg_gnt (dbg_gnt),
        .starve  (starve)
    );

    // Grants are gated by rst_n so every output is quiet while reset is held,
    // even though the grant path itself is purely combinational.
    always_comb begin
        dbg_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (rst_n) begin
            dbg_gnt = dbg_req & (~cpu_req | starve);
            cpu_gnt = cpu_req & ~dbg_gnt;
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Response FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response FSM: next state. Re-evaluated every cycle so reads can issue
    // back to back with no bubble.
    always_comb begin
        state_nxt = IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_nxt = CPU_RD;
        end else if (dbg_gnt && !dbg_we) begin
            state_nxt = DBG_RD;
        end
    end

    // Response FSM: outputs
    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        case (state)
            CPU_RD: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
            DBG_RD: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef DMEM_ARB_TRACE_EN
    logic [DW-1:0] trace_q;

    // A new CPU store beats a load result arriving in the same cycle: the
    // store was issued later in program order. Debug traffic never traces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else if (cpu_gnt && cpu_we) begin
            trace_q <= cpu_wdata;
        end else if (state == CPU_RD) begin
            trace_q <= mem_rdata;
        end
    end

    assign debug_dout = trace_q;
`else
    assign debug_dout = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int LIMIT = 4;

`ifdef DMEM_ARB_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] debug_dout;
    logic          busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .debug_dout(debug_dout), .busy(busy)
    );

    // Single-port synchronous RAM
    logic [DW-1:0] ram [256];
    logic          ram_clear = 1'b1;
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic drive_cpu(input logic we, input logic [7:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_dbg(input logic we, input logic [7:0] a, input logic [7:0] d);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic do_reset(input bit clr);
        @(negedge clk);
        drive_idle();
        rst_n = 0; ram_clear = clr;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1; ram_clear = 0;
    endtask

    typedef struct {
        logic       cr, cw; logic [7:0] ca, cd;
        logic       dr, dw; logic [7:0] da, dd;
        logic       e_cg, e_dg, e_we; logic [7:0] e_addr, e_wd;
    } vec_t;

    vec_t vecs [6];

    // Reference-model state (random phase)
    logic [7:0] mm [256];
    bit         c_pend, d_pend, c_w, d_w;
    logic [7:0] c_a, c_d, d_a, d_d;
    int         d_wait;
    int         rsp_kind;  // 0 none, 1 cpu, 2 dbg
    logic [7:0] rsp_data, exp_trace;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         exp_d, prev_c, prev_d, e_cg, e_dg;
        logic [7:0] e_addr, e_wd;
        logic       e_we;

        //            cr cw ca     cd     dr dw da     dd     cg dg we addr   wd
        vecs[0] = '{1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'hA5};
        vecs[1] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 8'h20, 8'h00};
        vecs[2] = '{1, 0, 8'h11, 8'h00, 1, 1, 8'h21, 8'h3C, 1, 0, 0, 8'h11, 8'h00};
        vecs[3] = '{0, 0, 8'h44, 8'h55, 0, 0, 8'h66, 8'h77, 0, 0, 0, 8'h00, 8'h00};
        vecs[4] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 1, 8'h20, 8'h3C};
        vecs[5] = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00};

        // ---- reset state, with a CPU request present while reset is held
        drive_idle();
        drive_cpu(1, 8'h33, 8'h99);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_debug_dout", debug_dout, 0);
        @(negedge clk);
        drive_idle();
        rst_n = 1; ram_clear = 0;

        // ---- single-cycle grant/mux table, idle cycle between entries
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
            dbg_req = vecs[i].dr; dbg_we = vecs[i].dw; dbg_addr = vecs[i].da; dbg_wdata = vecs[i].dd;
            #1;
            chk("tbl_cpu_gnt", cpu_gnt, vecs[i].e_cg);
            chk("tbl_dbg_gnt", dbg_gnt, vecs[i].e_dg);
            chk("tbl_mem_en", mem_en, vecs[i].e_cg | vecs[i].e_dg);
            chk("tbl_mem_we", mem_we, vecs[i].e_we);
            chk("tbl_mem_addr", mem_addr, vecs[i].e_addr);
            chk("tbl_mem_wdata", mem_wdata, vecs[i].e_wd);
            @(negedge clk);
            drive_idle();
        end

        do_reset(1);

        // ---- CPU store 0x10 <= 0xA5
        @(negedge clk);
        drive_cpu(1, 8'h10, 8'hA5);
        #1;
        chk("st_cpu_gnt", cpu_gnt, 1);
        chk("st_dbg_gnt", dbg_gnt, 0);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 8'h10);
        chk("st_mem_wdata", mem_wdata, 8'hA5);
        @(negedge clk);
        drive_idle();
        #1;
        chk("st_no_rvalid", cpu_rvalid, 0);
        chk("st_busy", busy, 0);
        chk("st_trace", debug_dout, TRACE ? 8'hA5 : 8'h00);

        // ---- CPU load 0x10
        @(negedge clk);
        drive_cpu(0, 8'h10, 8'h00);
        #1;
        chk("ld_cpu_gnt", cpu_gnt, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_rvalid_early", cpu_rvalid, 0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("ld_rvalid", cpu_rvalid, 1);
        chk("ld_rdata", cpu_rdata, 8'hA5);
        chk("ld_busy", busy, 1);
        chk("ld_dbg_rvalid", dbg_rvalid, 0);
        @(negedge clk);
        #1;
        chk("ld_rvalid_end", cpu_rvalid, 0);
        chk("ld_rdata_zero", cpu_rdata, 0);
        chk("ld_trace", debug_dout, TRACE ? 8'hA5 : 8'h00);

        // ---- debug store 0x20 <= 0x3C, must not touch the trace
        @(negedge clk);
        drive_dbg(1, 8'h20, 8'h3C);
        #1;
        chk("dst_dbg_gnt", dbg_gnt, 1);
        @(negedge clk);
        drive_idle();
        #1;
        chk("dst_trace", debug_dout, TRACE ? 8'hA5 : 8'h00);

        // ---- both requesting continuously: 4 CPU grants, then debug, repeat
        @(negedge clk);
        drive_cpu(0, 8'h10, 8'h00);
        drive_dbg(0, 8'h20, 8'h00);
        prev_c = 0; prev_d = 0;
        for (int c = 1; c <= 2 * (LIMIT + 1); c++) begin
            if (c > 1) @(negedge clk);
            #1;
            exp_d = ((c % (LIMIT + 1)) == 0);
            chk("starve_cpu_gnt", cpu_gnt, !exp_d);
            chk("starve_dbg_gnt", dbg_gnt, exp_d);
            chk("starve_cpu_rvalid", cpu_rvalid, prev_c);
            chk("starve_dbg_rvalid", dbg_rvalid, prev_d);
            chk("starve_cpu_rdata", cpu_rdata, prev_c ? 8'hA5 : 8'h00);
            chk("starve_dbg_rdata", dbg_rdata, prev_d ? 8'h3C : 8'h00);
            prev_c = !exp_d; prev_d = exp_d;
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("starve_last_dbg_rvalid", dbg_rvalid, 1);
        chk("starve_last_dbg_rdata", dbg_rdata, 8'h3C);

        // ---- alternating CPU/debug loads, trace must never pick up 0x3C
        prev_c = 0; prev_d = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_idle();
            if (i % 2 == 0) drive_cpu(0, 8'h10, 8'h00);
            else            drive_dbg(0, 8'h20, 8'h00);
            #1;
            chk("alt_cpu_gnt", cpu_gnt, (i % 2) == 0);
            chk("alt_dbg_gnt", dbg_gnt, (i % 2) == 1);
            chk("alt_cpu_rvalid", cpu_rvalid, prev_c);
            chk("alt_cpu_rdata", cpu_rdata, prev_c ? 8'hA5 : 8'h00);
            chk("alt_dbg_rvalid", dbg_rvalid, prev_d);
            chk("alt_dbg_rdata", dbg_rdata, prev_d ? 8'h3C : 8'h00);
            chk("alt_trace", debug_dout, TRACE ? 8'hA5 : 8'h00);
            prev_c = ((i % 2) == 0); prev_d = ((i % 2) == 1);
        end

        // ---- reset in the cycle after a CPU load grant drops the response
        @(negedge clk);
        drive_idle();
        drive_cpu(0, 8'h10, 8'h00);
        #1;
        chk("rmid_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        drive_idle();
        rst_n = 0;
        #1;
        chk("rmid_cpu_rvalid", cpu_rvalid, 0);
        chk("rmid_cpu_rdata", cpu_rdata, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_trace", debug_dout, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rpost_cpu_rvalid", cpu_rvalid, 0);
        chk("rpost_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("rpost2_cpu_rvalid", cpu_rvalid, 0);
        chk("rpost2_trace", debug_dout, 0);

        // ---- randomized traffic against the transaction-level model
        do_reset(1);
        for (int i = 0; i < 256; i++) mm[i] = '0;
        c_pend = 0; d_pend = 0; d_wait = 0; rsp_kind = 0; rsp_data = '0; exp_trace = '0;
        c_w = 0; d_w = 0; c_a = '0; c_d = '0; d_a = '0; d_d = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (!c_pend && $urandom_range(0, 2) != 0) begin
                c_pend = 1; c_w = 1'($urandom); c_a = 8'($urandom_range(0, 7)); c_d = 8'($urandom);
            end
            if (!d_pend && $urandom_range(0, 1) != 0) begin
                d_pend = 1; d_w = 1'($urandom); d_a = 8'($urandom_range(0, 7)); d_d = 8'($urandom);
            end
            cpu_req = c_pend; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
            dbg_req = d_pend; dbg_we = d_w; dbg_addr = d_a; dbg_wdata = d_d;
            #1;
            // Debug is served when CPU is absent or debug has waited LIMIT cycles.
            e_dg = d_pend && (!c_pend || d_wait >= LIMIT);
            e_cg = c_pend && !e_dg;
            e_we = e_cg ? c_w : (e_dg ? d_w : 1'b0);
            e_addr = e_cg ? c_a : (e_dg ? d_a : 8'h00);
            e_wd = e_cg ? c_d : (e_dg ? d_d : 8'h00);
            chk("rnd_cpu_gnt", cpu_gnt, e_cg);
            chk("rnd_dbg_gnt", dbg_gnt, e_dg);
            chk("rnd_mem_en", mem_en, e_cg | e_dg);
            chk("rnd_mem_we", mem_we, e_we);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_wd);
            chk("rnd_cpu_rvalid", cpu_rvalid, rsp_kind == 1);
            chk("rnd_cpu_rdata", cpu_rdata, (rsp_kind == 1) ? rsp_data : 8'h00);
            chk("rnd_dbg_rvalid", dbg_rvalid, rsp_kind == 2);
            chk("rnd_dbg_rdata", dbg_rdata, (rsp_kind == 2) ? rsp_data : 8'h00);
            chk("rnd_busy", busy, rsp_kind != 0);
            chk("rnd_trace", debug_dout, TRACE ? exp_trace : 8'h00);

            // Advance the model by one cycle.
            if (e_cg && c_w) exp_trace = c_d;
            else if (rsp_kind == 1) exp_trace = rsp_data;
            rsp_kind = 0;
            if (e_cg && !c_w) begin rsp_kind = 1; rsp_data = mm[c_a]; end
            if (e_dg && !d_w) begin rsp_kind = 2; rsp_data = mm[d_a]; end
            if (e_cg && c_w) mm[c_a] = c_d;
            if (e_dg && d_w) mm[d_a] = d_d;
            if (d_pend && !e_dg) d_wait = (d_wait < LIMIT) ? d_wait + 1 : LIMIT;
            else d_wait = 0;
            if (e_cg) c_pend = 0;
            if (e_dg) d_pend = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, data-memory address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max cycles debug port waits while CPU holds priority; legal range 1..15.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU LD/ST request, write strobe.
REQ-007 cpu_addr / cpu_wdata  in  AW / DW  CPU address, ST data.
REQ-008 cpu_gnt  out  1  CPU access issued this cycle.
REQ-009 cpu_rvalid / cpu_rdata  out  1 / DW  CPU LD response.
REQ-010 dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/AW/DW  debug-host port, same meaning as CPU.
REQ-011 dbg_gnt / dbg_rvalid / dbg_rdata  out  1/1/DW  debug grant and read response.
REQ-012 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  to single-port synchronous RAM.
REQ-013 mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-014 debug_dout  out  DW  trace of last CPU ST data or LD result.
REQ-015 busy  out  1  response pending (state != IDLE).

Function
REQ-016 Grant decided combinationally each cycle; at most one of cpu_gnt/dbg_gnt high; gnt only when matching req high.
REQ-017 Priority: CPU wins ties unless age counter == STARVE_LIMIT, then debug wins.
REQ-018 Age counter: +1 per cycle dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT; cleared on dbg_gnt or dbg_req=0.
REQ-019 mem_en = cpu_gnt|dbg_gnt; mem_we/addr/wdata muxed from granted port same cycle; all zero when no grant.
REQ-020 Response FSM states IDLE, CPU_RD, DBG_RD; next state = CPU_RD on granted CPU read, DBG_RD on granted debug read, else IDLE; evaluated every cycle (back-to-back reads allowed, no bubble).
REQ-021 In CPU_RD: cpu_rvalid=1, cpu_rdata=mem_rdata; in DBG_RD: dbg_rvalid=1, dbg_rdata=mem_rdata; rdata outputs 0 when matching rvalid low.
REQ-022 Writes produce no rvalid; read latency exactly 1 cycle after gnt.
REQ-023 Requests not granted hold; arbiter keeps no request queue—requester keeps req/addr/data stable until gnt.

Reset
REQ-024 On rst_n low: state IDLE, age 0, debug_dout 0, all outputs 0 regardless of clock.
REQ-025 Reset mid-read SHALL drop pending rvalid; no response after deassertion.

Configuration
REQ-026 Macro DMEM_ARB_TRACE_EN defined: debug_dout <= cpu_wdata on cycle of CPU write grant; debug_dout <= mem_rdata in CPU_RD state; else hold.
REQ-027 Same cycle CPU_RD response and new CPU write grant: write data wins (program order).
REQ-028 Debug-port traffic never updates debug_dout.
REQ-029 Macro undefined: debug_dout constant 0, no trace register synthesized.

Structure
REQ-030 Package dmem_arb_pkg holds response-state enum (IDLE, CPU_RD, DBG_RD) and default width/limit constants.
REQ-031 Sub-module dmem_arb_age_ctr implements saturating age counter and starve flag; remainder in dmem_arbiter.

Verification
REQ-032 CPU ST addr 0x10 data 0xA5, debug idle -> cpu_gnt same cycle, mem_we=1 mem_addr=0x10, no rvalid, debug_dout=0xA5 next cycle (TRACE_EN).
REQ-033 CPU LD 0x10 after REQ-032 -> cpu_rvalid 1 cycle later with cpu_rdata=0xA5, debug_dout=0xA5.
REQ-034 cpu_req and dbg_req both held continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, debug granted cycle 5, age clears, CPU resumes.
REQ-035 Debug LD 0x20 (RAM holds 0x3C) alternating with CPU LD 0x10 -> dbg_rvalid only with 0x3C, cpu_rvalid only with 0xA5, debug_dout never 0x3C.
REQ-036 rst_n asserted in cycle after CPU LD grant -> no cpu_rvalid, busy=0, debug_dout=0.
REQ-037 Build without DMEM_ARB_TRACE_EN, rerun REQ-032 -> debug_dout stays 0, arbitration identical.
